// File: rtl/nco_pkg.sv
// Shared defaults and state encoding for the NCO phase/address generator.
package nco_pkg;

    localparam int NCO_ACC_WIDTH  = 32;
    localparam int NCO_ADDR_WIDTH = 10;
    localparam int NCO_LEN_WIDTH  = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } nco_state_e;

endpackage : nco_pkg

// File: rtl/nco_phase_gen.sv
// NCO phase accumulator that emits sine-LUT read addresses for fixed-length
// pulses. The config is double-buffered: a shadow register accepts a new
// {ftw, phase, len} at any time, and it becomes active only at the next start.
module nco_phase_gen
    import nco_pkg::*;
#(
    parameter int ACC_WIDTH  = NCO_ACC_WIDTH,
    parameter int ADDR_WIDTH = NCO_ADDR_WIDTH,
    parameter int LEN_WIDTH  = NCO_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ACC_WIDTH-1:0]  cfg_ftw,
    input  logic [ADDR_WIDTH-1:0] cfg_phase,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  addr_valid,
    output logic                  busy,
    output logic                  done
);

    nco_state_e            state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  addr_valid_q, addr_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // cfg_ready_q high means the shadow register is empty.
    logic                  cfg_ready_q, cfg_ready_d;
    logic [ACC_WIDTH-1:0]  sh_ftw_q, sh_ftw_d;
    logic [ADDR_WIDTH-1:0] sh_phase_q, sh_phase_d;
    logic [LEN_WIDTH-1:0]  sh_len_q, sh_len_d;
    logic [ACC_WIDTH-1:0]  act_ftw_q, act_ftw_d;
    logic [ADDR_WIDTH-1:0] act_phase_q, act_phase_d;
    logic [LEN_WIDTH-1:0]  act_len_q, act_len_d;

    logic                  take_start;
    logic                  copy_shadow;
    logic [ADDR_WIDTH-1:0] eff_phase;
    logic [LEN_WIDTH-1:0]  eff_len;
    logic [ACC_WIDTH-1:0]  acc_next;

    // Next-state logic: shadow handshake, start/abort handling, accumulator stepping.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        rem_d        = rem_q;
        rd_addr_d    = rd_addr_q;
        addr_valid_d = addr_valid_q;
        done_d       = 1'b0;
        cfg_ready_d  = cfg_ready_q;
        sh_ftw_d     = sh_ftw_q;
        sh_phase_d   = sh_phase_q;
        sh_len_d     = sh_len_q;
        act_ftw_d    = act_ftw_q;
        act_phase_d  = act_phase_q;
        act_len_d    = act_len_q;
        acc_next     = acc_q + act_ftw_q;

        // start together with abort is a no-op, including for the shadow.
        take_start  = (state_q == ST_IDLE) && start && !abort;
        copy_shadow = take_start && !cfg_ready_q;
        eff_phase   = copy_shadow ? sh_phase_q : act_phase_q;
        eff_len     = copy_shadow ? sh_len_q   : act_len_q;

        // A load needs an empty shadow and a copy needs a full one, so the
        // two never compete for cfg_ready_d in the same cycle.
        if (cfg_valid && cfg_ready_q) begin
            sh_ftw_d    = cfg_ftw;
            sh_phase_d  = cfg_phase;
            sh_len_d    = cfg_len;
            cfg_ready_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (take_start) begin
                    if (copy_shadow) begin
                        act_ftw_d   = sh_ftw_q;
                        act_phase_d = sh_phase_q;
                        act_len_d   = sh_len_q;
                        cfg_ready_d = 1'b1;
                    end
                    acc_d = '0;
                    rem_d = eff_len;
                    if (eff_len != '0) begin
                        state_d      = ST_RUN;
                        addr_valid_d = 1'b1;
                        // Accumulator top bits are zero on the first sample.
                        rd_addr_d    = eff_phase;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d      = ST_IDLE;
                    addr_valid_d = 1'b0;
                end else if (rem_q == LEN_WIDTH'(1)) begin
                    state_d      = ST_IDLE;
                    addr_valid_d = 1'b0;
                    done_d       = 1'b1;
                end else begin
                    acc_d     = acc_next;
                    rd_addr_d = acc_next[ACC_WIDTH-1 -: ADDR_WIDTH] + act_phase_q;
                    rem_d     = rem_q - LEN_WIDTH'(1);
                end
            end
            default: begin
                state_d      = ST_IDLE;
                addr_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d == ST_RUN);
    end

    // State, datapath and config registers; reset clears everything and empties the shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            rem_q        <= '0;
            rd_addr_q    <= '0;
            addr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_ready_q  <= 1'b1;
            sh_ftw_q     <= '0;
            sh_phase_q   <= '0;
            sh_len_q     <= '0;
            act_ftw_q    <= '0;
            act_phase_q  <= '0;
            act_len_q    <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            rem_q        <= rem_d;
            rd_addr_q    <= rd_addr_d;
            addr_valid_q <= addr_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_ready_q  <= cfg_ready_d;
            sh_ftw_q     <= sh_ftw_d;
            sh_phase_q   <= sh_phase_d;
            sh_len_q     <= sh_len_d;
            act_ftw_q    <= act_ftw_d;
            act_phase_q  <= act_phase_d;
            act_len_q    <= act_len_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign rd_addr    = rd_addr_q;
    assign addr_valid = addr_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule : nco_phase_gen

// File: tb/tb_nco_phase_gen.sv
// Randomized and directed bench for nco_phase_gen with a behavioural model.
module tb_nco_phase_gen;

    localparam int ACC_W  = 32;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [ACC_W-1:0]  cfg_ftw = '0;
    logic [ADDR_W-1:0] cfg_phase = '0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] rd_addr;
    logic              addr_valid;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the config registers.
    logic              m_sh_full = 1'b0;
    logic [ACC_W-1:0]  m_sh_ftw = '0;
    logic [ADDR_W-1:0] m_sh_phase = '0;
    logic [LEN_W-1:0]  m_sh_len = '0;
    logic [ACC_W-1:0]  m_act_ftw = '0;
    logic [ADDR_W-1:0] m_act_phase = '0;
    logic [LEN_W-1:0]  m_act_len = '0;

    nco_phase_gen #(
        .ACC_WIDTH (ACC_W),
        .ADDR_WIDTH(ADDR_W),
        .LEN_WIDTH (LEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ftw   (cfg_ftw),
        .cfg_phase (cfg_phase),
        .cfg_len   (cfg_len),
        .start     (start),
        .abort     (abort),
        .rd_addr   (rd_addr),
        .addr_valid(addr_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Sample i of a pulse: phase after i steps is i*ftw, truncated to its top bits, plus offset.
    function automatic logic [ADDR_W-1:0] exp_addr(input int unsigned i);
        logic [ACC_W-1:0] acc;
        acc = m_act_ftw * i;
        return acc[ACC_W-1 -: ADDR_W] + m_act_phase;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer_cfg(input logic [ACC_W-1:0] f, input logic [ADDR_W-1:0] p,
                             input logic [LEN_W-1:0] l);
        cfg_ftw   = f;
        cfg_phase = p;
        cfg_len   = l;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        if (!m_sh_full) begin
            m_sh_full  = 1'b1;
            m_sh_ftw   = f;
            m_sh_phase = p;
            m_sh_len   = l;
        end
    endtask

    task automatic press_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (m_sh_full) begin
            m_act_ftw   = m_sh_ftw;
            m_act_phase = m_sh_phase;
            m_act_len   = m_sh_len;
            m_sh_full   = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        tick();
        tick();
        checks++;
        if ({busy, addr_valid, done, cfg_ready, rd_addr} !== {3'b000, 1'b1, {ADDR_W{1'b0}}}) begin
            errors++;
            $display("FAIL reset_state: busy=%0b valid=%0b done=%0b ready=%0b addr=%0d, expected 0 0 0 1 0",
                     busy, addr_valid, done, cfg_ready, rd_addr);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, addr_valid, done, cfg_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%0b valid=%0b done=%0b ready=%0b, expected 0 0 0 1",
                     busy, addr_valid, done, cfg_ready);
        end
    endtask

    task automatic test_ramp();
        offer_cfg(32'h0040_0000, 10'd0, 16'd1024);
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL ramp_cfg_ready_low: got %0b expected 0", cfg_ready);
        end
        press_start();
        for (int i = 0; i < 1024; i++) begin
            checks++;
            if (addr_valid !== 1'b1 || rd_addr !== ADDR_W'(i)) begin
                errors++;
                $display("FAIL ramp_sample %0d: valid=%0b addr=%0d, expected 1 %0d", i, addr_valid, rd_addr, i);
            end
            tick();
        end
        checks++;
        if ({addr_valid, done, busy, cfg_ready} !== 4'b0101) begin
            errors++;
            $display("FAIL ramp_done: valid=%0b done=%0b busy=%0b ready=%0b, expected 0 1 0 1",
                     addr_valid, done, busy, cfg_ready);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL ramp_done_one_cycle: done=%0b expected 0", done);
        end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] wrap_exp [4];
        wrap_exp = '{10'd1020, 10'd1022, 10'd0, 10'd2};
        offer_cfg(32'h0080_0000, 10'd1020, 16'd4);
        press_start();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (addr_valid !== 1'b1 || rd_addr !== wrap_exp[i]) begin
                errors++;
                $display("FAIL wrap_sample %0d: valid=%0b addr=%0d, expected 1 %0d",
                         i, addr_valid, rd_addr, wrap_exp[i]);
            end
            tick();
        end
        checks++;
        if ({addr_valid, done} !== 2'b01) begin
            errors++;
            $display("FAIL wrap_done: valid=%0b done=%0b, expected 0 1", addr_valid, done);
        end
        tick();
    endtask

    task automatic test_len_zero();
        offer_cfg(32'd1234, 10'd7, 16'd0);
        press_start();
        checks++;
        if ({addr_valid, busy, done} !== 3'b001) begin
            errors++;
            $display("FAIL len0_done: valid=%0b busy=%0b done=%0b, expected 0 0 1", addr_valid, busy, done);
        end
        tick();
        checks++;
        if ({addr_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL len0_after: valid=%0b busy=%0b done=%0b, expected 0 0 0", addr_valid, busy, done);
        end
    endtask

    task automatic test_abort();
        logic [ADDR_W-1:0] last;
        offer_cfg(32'h0123_4567, 10'd300, 16'd100);
        press_start();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (addr_valid !== 1'b1 || rd_addr !== exp_addr(i)) begin
                errors++;
                $display("FAIL abort_pre_sample %0d: valid=%0b addr=%0d, expected 1 %0d",
                         i, addr_valid, rd_addr, exp_addr(i));
            end
            if (i == 9) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        last = exp_addr(9);
        checks++;
        if ({addr_valid, busy, done} !== 3'b000 || rd_addr !== last) begin
            errors++;
            $display("FAIL abort_stop: valid=%0b busy=%0b done=%0b addr=%0d, expected 0 0 0 %0d",
                     addr_valid, busy, done, rd_addr, last);
        end
        tick();
        checks++;
        if (done !== 1'b0 || rd_addr !== last) begin
            errors++;
            $display("FAIL abort_no_done: done=%0b addr=%0d, expected 0 %0d", done, rd_addr, last);
        end
        press_start();
        for (int i = 0; i < 100; i++) begin
            checks++;
            if (addr_valid !== 1'b1 || rd_addr !== exp_addr(i)) begin
                errors++;
                $display("FAIL abort_replay_sample %0d: valid=%0b addr=%0d, expected 1 %0d",
                         i, addr_valid, rd_addr, exp_addr(i));
            end
            tick();
        end
        checks++;
        if ({addr_valid, done} !== 2'b01) begin
            errors++;
            $display("FAIL abort_replay_done: valid=%0b done=%0b, expected 0 1", addr_valid, done);
        end
        tick();
    endtask

    task automatic test_cfg_during_run();
        offer_cfg(32'h0040_0000, 10'd5, 16'd20);
        press_start();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (addr_valid !== 1'b1 || rd_addr !== exp_addr(i)) begin
                errors++;
                $display("FAIL cfgrun_sample %0d: valid=%0b addr=%0d, expected 1 %0d",
                         i, addr_valid, rd_addr, exp_addr(i));
            end
            if (i == 3) begin
                cfg_ftw   = 32'h00C0_0000;
                cfg_phase = 10'd100;
                cfg_len   = 16'd8;
                cfg_valid = 1'b1;
            end
            if (i == 8) start = 1'b1;
            tick();
            start = 1'b0;
            if (i == 3) begin
                cfg_valid  = 1'b0;
                m_sh_full  = 1'b1;
                m_sh_ftw   = 32'h00C0_0000;
                m_sh_phase = 10'd100;
                m_sh_len   = 16'd8;
                checks++;
                if (cfg_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL cfgrun_ready_fall: got %0b expected 0", cfg_ready);
                end
            end
        end
        checks++;
        if ({addr_valid, done, cfg_ready} !== 3'b010) begin
            errors++;
            $display("FAIL cfgrun_done: valid=%0b done=%0b ready=%0b, expected 0 1 0",
                     addr_valid, done, cfg_ready);
        end
        tick();
        press_start();
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfgrun_ready_rise: got %0b expected 1", cfg_ready);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (addr_valid !== 1'b1 || rd_addr !== exp_addr(i)) begin
                errors++;
                $display("FAIL cfgrun_new_sample %0d: valid=%0b addr=%0d, expected 1 %0d",
                         i, addr_valid, rd_addr, exp_addr(i));
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL cfgrun_new_done: done=%0b expected 1", done);
        end
        tick();
    endtask

    task automatic test_start_abort_idle();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({busy, addr_valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL idle_abort: busy=%0b valid=%0b done=%0b, expected 0 0 0", busy, addr_valid, done);
        end
        offer_cfg($urandom, 10'($urandom_range(0, 1023)), 16'd3);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if ({busy, addr_valid, done, cfg_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_start_abort: busy=%0b valid=%0b done=%0b ready=%0b, expected 0 0 0 0",
                     busy, addr_valid, done, cfg_ready);
        end
        press_start();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (addr_valid !== 1'b1 || rd_addr !== exp_addr(i)) begin
                errors++;
                $display("FAIL sa_sample %0d: valid=%0b addr=%0d, expected 1 %0d",
                         i, addr_valid, rd_addr, exp_addr(i));
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL sa_done: done=%0b expected 1", done);
        end
        tick();
    endtask

    task automatic test_random();
        int unsigned len;
        for (int n = 0; n < 8; n++) begin
            len = $urandom_range(1, 40);
            offer_cfg($urandom, 10'($urandom_range(0, 1023)), LEN_W'(len));
            press_start();
            for (int i = 0; i < int'(len); i++) begin
                checks++;
                if (addr_valid !== 1'b1 || busy !== 1'b1 || rd_addr !== exp_addr(i)) begin
                    errors++;
                    $display("FAIL rand %0d sample %0d: valid=%0b busy=%0b addr=%0d, expected 1 1 %0d",
                             n, i, addr_valid, busy, rd_addr, exp_addr(i));
                end
                if (len >= 4 && i == int'(len / 2)) start = 1'b1;
                tick();
                start = 1'b0;
            end
            checks++;
            if ({addr_valid, busy, done} !== 3'b001) begin
                errors++;
                $display("FAIL rand %0d done: valid=%0b busy=%0b done=%0b, expected 0 0 1",
                         n, addr_valid, busy, done);
            end
            repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    task automatic test_async_reset();
        offer_cfg($urandom, 10'd33, 16'd50);
        press_start();
        tick();
        offer_cfg($urandom, 10'd44, 16'd9);
        tick();
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, addr_valid, done, cfg_ready, rd_addr} !== {3'b000, 1'b1, {ADDR_W{1'b0}}}) begin
            errors++;
            $display("FAIL async_reset: busy=%0b valid=%0b done=%0b ready=%0b addr=%0d, expected 0 0 0 1 0",
                     busy, addr_valid, done, cfg_ready, rd_addr);
        end
        tick();
        rst_n       = 1'b1;
        m_sh_full   = 1'b0;
        m_act_ftw   = '0;
        m_act_phase = '0;
        m_act_len   = '0;
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL async_no_done: busy=%0b done=%0b, expected 0 0", busy, done);
        end
        press_start();
        checks++;
        if ({addr_valid, busy, done} !== 3'b001) begin
            errors++;
            $display("FAIL async_len0_start: valid=%0b busy=%0b done=%0b, expected 0 0 1",
                     addr_valid, busy, done);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_wrap();
        test_len_zero();
        test_abort();
        test_cfg_during_run();
        test_start_abort_idle();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_nco_phase_gen

// File: doc/nco_phase_gen.md
NCO_PHASE_GEN -- requirements
Module: nco_phase_gen

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 32: phase accumulator width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: LUT address width (1024 entries).
REQ-003 SHALL have parameter LEN_WIDTH, default 16: pulse sample-count width.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port cfg_valid, input, 1: config offer.
REQ-007 SHALL have port cfg_ready, output, 1: shadow config register empty.
REQ-008 SHALL have port cfg_ftw, input, ACC_WIDTH: frequency tuning word.
REQ-009 SHALL have port cfg_phase, input, ADDR_WIDTH: phase offset in LUT steps.
REQ-010 SHALL have port cfg_len, input, LEN_WIDTH: samples per pulse.
REQ-011 SHALL have port start, input, 1: begin a pulse.
REQ-012 SHALL have port abort, input, 1: terminate the current pulse.
REQ-013 SHALL have port rd_addr, output, ADDR_WIDTH: address to sin_lut_n1024_16b.
REQ-014 SHALL have port addr_valid, output, 1: rd_addr is a live sample.
REQ-015 SHALL have port busy, output, 1: state is RUN.
REQ-016 SHALL have port done, output, 1: one-cycle end-of-pulse strobe.

Function
REQ-017 Config transfer SHALL occur on a clock edge where cfg_valid and cfg_ready are both high. The transfer loads the shadow {ftw, phase, len}, and cfg_ready falls on the next cycle.
REQ-018 cfg_ready SHALL rise again only when the shadow is copied into the active config.
REQ-019 Config SHALL be accepted in any state. It never alters a pulse already running.
REQ-020 The FSM SHALL have two states: IDLE and RUN. busy = (state == RUN).
REQ-021 In IDLE, start=1 with abort=0 at edge k SHALL perform all of the following:
- If the shadow is full, copy it to active; otherwise keep the previous active config.
- Clear the accumulator to 0.
- Set remaining = active len.
REQ-022 In the case of REQ-021 with len > 0, after edge k:
- state = RUN, addr_valid = 1;
- rd_addr = active phase, i.e. accumulator top ADDR_WIDTH bits (0) + phase, mod 2^ADDR_WIDTH.
REQ-023 Each later RUN edge with remaining > 1 SHALL:
- add ftw to the accumulator (mod 2^ACC_WIDTH);
- set rd_addr = acc_next[ACC_WIDTH-1 -: ADDR_WIDTH] + phase, mod 2^ADDR_WIDTH (truncate, no rounding);
- decrement remaining.
REQ-024 A RUN edge with remaining == 1 SHALL set state = IDLE, addr_valid = 0 and done = 1 for exactly one cycle. Exactly len valid samples are produced per pulse.
REQ-025 start with active len == 0 SHALL produce no valid samples. State stays IDLE and done = 1 for one cycle after edge k.
REQ-026 start asserted during RUN SHALL be ignored. No queuing.
REQ-027 abort=1 in RUN SHALL force IDLE and addr_valid = 0 on the next edge, with no done pulse. abort SHALL take priority over start and over the final-sample transition.
REQ-028 abort in IDLE SHALL have no effect. start and abort together in IDLE SHALL leave state IDLE and leave the shadow untouched.
REQ-029 rd_addr SHALL hold its last value whenever addr_valid = 0.
REQ-030 All outputs SHALL be registered. The downstream LUT's read latency is the consumer's responsibility.

Reset
REQ-031 rst_n low SHALL immediately set the following, independent of clk:
- state = IDLE;
- accumulator, rd_addr, remaining = 0;
- addr_valid = 0, busy = 0, done = 0;
- shadow empty (cfg_ready = 1);
- active config = 0.
REQ-032 Reset mid-pulse SHALL abandon the pulse with no done strobe. The first post-reset start uses len = 0 unless a new config was accepted.

Structure
REQ-033 Package nco_pkg SHALL hold ACC_WIDTH, ADDR_WIDTH, LEN_WIDTH defaults and the IDLE/RUN state enum typedef.
REQ-034 The block SHALL be a single flat module with no sub-module. Accumulator, counter and FSM are too small to split.

Verification
REQ-035 ftw=2^22, phase=0, len=1024, then start: rd_addr SHALL read 0,1,...,1023 on 1024 consecutive valid cycles, followed by done=1 for one cycle.
REQ-036 ftw=2^23, phase=1020, len=4: rd_addr SHALL read 1020, 1022, 0, 2 (wrap-around), then done.
REQ-037 len=0 then start: addr_valid SHALL stay 0 and done=1 one cycle after start.
REQ-038 len=100, abort on sample 10: addr_valid=0 on the next cycle, no done; a new start then replays from rd_addr = phase.
REQ-039 Config offered during RUN: cfg_ready SHALL fall after the load and the running pulse SHALL be unchanged. The next start SHALL use the new ftw and raise cfg_ready.
REQ-040 rst_n pulsed low asynchronously mid-pulse: all outputs SHALL be 0 immediately, with cfg_ready = 1.
